// File: rtl/hsync_fsm_pkg.sv
// hsync_fsm_pkg: line phase lengths, pixel divider and state encodings shared with the upstream counter
package hsync_fsm_pkg;
  typedef enum logic [1:0] {ST_B = 2'd0, ST_C = 2'd1, ST_D = 2'd2, ST_E = 2'd3} hstate_t;
  localparam int T_B = 384;
  localparam int T_C = 192;
  localparam int T_D = 2560;
  localparam int T_E = 64;
  localparam int T_A = T_B + T_C + T_D + T_E;
  localparam int PIX_DIV = 4;
  localparam int COL_W = 10;
endpackage

// File: rtl/hsync_fsm_if.sv
// hsync_fsm_if: counter-boundary inputs and horizontal timing outputs of the hsync FSM
interface hsync_fsm_if #(parameter int COL_W = 10);
  logic flagR, enable_state, hsync, hdisp, line_end;
  logic [COL_W-1:0] col;
  modport master(output flagR, enable_state, input hsync, hdisp, col, line_end);
  modport slave(input flagR, enable_state, output hsync, hdisp, col, line_end);
endinterface

// File: rtl/hsync_fsm_pixel_col_counter.sv
// pixel_col_counter: divides qualified display cycles into pixel columns, saturating at the last column
module pixel_col_counter #(
  parameter int PIX_DIV = 4,
  parameter int COL_W = 10,
  parameter int COL_MAX = 639
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             qualify,
  output logic [COL_W-1:0] col
);
  localparam int PW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  logic [PW-1:0] pdiv;
  logic          last;
  assign last = pdiv == PW'(PIX_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pdiv <= '0;
      col <= '0;
    end else if (clear || !enable) begin
      pdiv <= '0;
      col <= '0;
    end else if (qualify) begin
      pdiv <= last ? '0 : pdiv + 1'b1;
      if (last && col != COL_W'(COL_MAX)) col <= col + 1'b1;
    end
endmodule

// File: rtl/hsync_fsm.sv
// hsync_fsm: Moore B/C/D/E horizontal timing FSM stepped by qualified counter boundaries
module hsync_fsm
  import hsync_fsm_pkg::*;
#(
  parameter int T_D = hsync_fsm_pkg::T_D,
  parameter int PIX_DIV = hsync_fsm_pkg::PIX_DIV,
  parameter int COL_W = hsync_fsm_pkg::COL_W
) (
  input logic        clk,
  input logic        reset,
  hsync_fsm_if.slave bus
);
  hstate_t state, nxt;
  logic    adv;
  assign adv = bus.flagR && bus.enable_state;
  // B->C->D->E->B is a plain 2-bit increment, so every encoding has a defined successor
  always_comb nxt = adv ? hstate_t'(state + 2'd1) : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_B;
      bus.hsync <= 1'b0;
      bus.hdisp <= 1'b0;
      bus.line_end <= 1'b0;
    end else begin
      state <= nxt;
      bus.hsync <= nxt != ST_B;
      bus.hdisp <= nxt == ST_D;
      bus.line_end <= adv && state == ST_E;
    end
  pixel_col_counter #(.PIX_DIV(PIX_DIV), .COL_W(COL_W), .COL_MAX(T_D / PIX_DIV - 1)) u_col (
    .clk    (clk),
    .reset  (reset),
    .clear  (adv),
    .enable (state == ST_D),
    .qualify(bus.flagR),
    .col    (bus.col)
  );
endmodule

// File: tb/tb_hsync_fsm.sv
// tb_hsync_fsm: upstream counter model drives the FSM; expected outputs are queued and checked by a monitor
module tb_hsync_fsm;
  import hsync_fsm_pkg::*;
  typedef struct packed {
    logic       hsync;
    logic       hdisp;
    logic [9:0] col;
    logic       line_end;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  hsync_fsm_if #(.COL_W(10)) bus ();
  hsync_fsm dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.enable_state = n == T_B - 1 || n == T_B + T_C - 1 || n == T_B + T_C + T_D - 1 || n == T_A - 1;
  function automatic exp_t expect_of(input int cnt, input logic wrap);
    exp_t e;
    e.hsync = cnt >= 384;
    e.hdisp = cnt >= 576 && cnt < 3136;
    e.col = e.hdisp ? 10'((cnt - 576) / 4) : 10'd0;
    e.line_end = wrap;
    return e;
  endfunction
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {bus.hsync, bus.hdisp, bus.col, bus.line_end};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL out n=%0d got hsync=%b hdisp=%b col=%0d line_end=%b want hsync=%b hdisp=%b col=%0d line_end=%b",
                 n, a.hsync, a.hdisp, a.col, a.line_end, e.hsync, e.hdisp, e.col, e.line_end);
      end
    end
  task automatic step(input logic f);
    logic w;
    bus.flagR = f;
    w = f && n == T_A - 1;
    @(posedge clk);
    #1;
    if (f) n = n == T_A - 1 ? 0 : n + 1;
    q.push_back(expect_of(n, w));
  endtask
  task automatic check_reset(input string tag);
    checks++;
    if ({bus.hsync, bus.hdisp, bus.col, bus.line_end} !== 13'd0) begin
      errors++;
      $display("FAIL %s got hsync=%b hdisp=%b col=%0d line_end=%b want all 0", tag, bus.hsync, bus.hdisp, bus.col, bus.line_end);
    end
  endtask
  initial begin
    bus.flagR = 1'b0;
    #12;
    check_reset("reset_state");
    #11 reset = 1'b1;
    for (int i = 0; i < 3 * 3200 + 5; i++) step(1'b1);
    for (int i = 0; i < 2 * 3200 + 10; i++) step(i % 2 == 0);
    for (int i = 0; i < 7; i++) step(1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    n = 0;
    #3 reset = 1'b1;
    for (int i = 0; i < 1000; i++) step(1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (bus.col !== 10'd106 || bus.hdisp !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_col got col=%0d hdisp=%b want col=106 hdisp=1", bus.col, bus.hdisp);
    end
    reset = 1'b0;
    #1 check_reset("async_reset");
    n = 0;
    repeat (2) @(posedge clk);
    #1 check_reset("held_reset");
    #2 reset = 1'b1;
    for (int i = 0; i < 3200 + 20; i++) step(1'b1);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
